// File: rtl/start_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | start_pkg                                                                |
// | Shared types for the start-screen sequencer and its helpers.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package start_pkg;

    localparam int c_coord_w = 11;

    typedef logic [c_coord_w-1:0] coord_t;

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        BLINK   = 2'd1,
        EXIT    = 2'd2,
        DONE    = 2'd3
    } start_state_t;

    // Bits needed to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_offset_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rect_offset_calc                                                         |
// | Registered rectangle hit test and offset from the rectangle origin.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rect_offset_calc
    import start_pkg::*;
#(
    parameter int TOP_LEFT_X = 320,
    parameter int TOP_LEFT_Y = 220,
    parameter int RECT_W     = 110,
    parameter int RECT_H     = 50
) (
    input  logic   clk,
    input  logic   reset,
    input  coord_t i_pixel_x,
    input  coord_t i_pixel_y,
    output coord_t o_offset_x,
    output coord_t o_offset_y,
    output logic   o_hit
);

    // Bounds are kept one bit wider than a coordinate so the far edge cannot wrap.
    localparam logic [c_coord_w:0] c_x_lo = (c_coord_w + 1)'(TOP_LEFT_X);
    localparam logic [c_coord_w:0] c_x_hi = (c_coord_w + 1)'(TOP_LEFT_X + RECT_W);
    localparam logic [c_coord_w:0] c_y_lo = (c_coord_w + 1)'(TOP_LEFT_Y);
    localparam logic [c_coord_w:0] c_y_hi = (c_coord_w + 1)'(TOP_LEFT_Y + RECT_H);
    localparam coord_t             c_x_org = coord_t'(TOP_LEFT_X);
    localparam coord_t             c_y_org = coord_t'(TOP_LEFT_Y);

    logic [c_coord_w:0] w_px;
    logic [c_coord_w:0] w_py;
    logic               w_hit;
    coord_t             w_dx;
    coord_t             w_dy;

    assign w_px  = {1'b0, i_pixel_x};
    assign w_py  = {1'b0, i_pixel_y};
    assign w_hit = (w_px >= c_x_lo) && (w_px < c_x_hi) &&
                   (w_py >= c_y_lo) && (w_py < c_y_hi);
    assign w_dx  = i_pixel_x - c_x_org;
    assign w_dy  = i_pixel_y - c_y_org;

    logic   r_hit;
    coord_t r_offset_x;
    coord_t r_offset_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit      <= 1'b0;
            r_offset_x <= '0;
            r_offset_y <= '0;
        end else begin
            r_hit      <= w_hit;
            r_offset_x <= w_hit ? w_dx : '0;
            r_offset_y <= w_hit ? w_dy : '0;
        end
    end

    assign o_hit      = r_hit;
    assign o_offset_x = r_offset_x;
    assign o_offset_y = r_offset_y;

endmodule
`default_nettype wire

// File: rtl/start_screen_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | start_screen_ctrl                                                        |
// | Start-screen sequencer: prompt blink, key debounce, exit blink, handoff. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module start_screen_ctrl
    import start_pkg::*;
#(
    parameter int TOP_LEFT_X      = 320,
    parameter int TOP_LEFT_Y      = 220,
    parameter int RECT_W          = 110,
    parameter int RECT_H          = 50,
    parameter int BLINK_FRAMES    = 30,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int EXIT_FRAMES     = 60,
    parameter int EXIT_BLINK      = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  logic   startOfFrame,
    input  logic   startKey,
    input  logic   gameOver,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   insideRectangle,
    output logic   screenActive,
    output logic   gameStart
);

    localparam int c_frm_w  = cnt_width((BLINK_FRAMES > EXIT_BLINK) ? BLINK_FRAMES : EXIT_BLINK);
    localparam int c_exit_w = cnt_width(EXIT_FRAMES);
    localparam int c_deb_w  = cnt_width(DEBOUNCE_FRAMES);

    localparam logic [c_frm_w-1:0]  c_blink_n  = c_frm_w'(BLINK_FRAMES);
    localparam logic [c_frm_w-1:0]  c_xblink_n = c_frm_w'(EXIT_BLINK);
    localparam logic [c_exit_w-1:0] c_exit_n   = c_exit_w'(EXIT_FRAMES);
    localparam logic [c_deb_w-1:0]  c_deb_n    = c_deb_w'(DEBOUNCE_FRAMES);

    start_state_t          r_state,      w_state_nxt;
    logic                  r_phase,      w_phase_nxt;
    logic [c_frm_w-1:0]    r_frame_cnt,  w_frame_nxt,  w_frame_inc;
    logic [c_exit_w-1:0]   r_exit_cnt,   w_exit_nxt,   w_exit_inc;
    logic [c_deb_w-1:0]    r_deb_cnt,    w_deb_nxt,    w_deb_inc;
    logic                  r_game_start, w_game_start_nxt;
    logic                  w_hit;

    rect_offset_calc #(
        .TOP_LEFT_X (TOP_LEFT_X),
        .TOP_LEFT_Y (TOP_LEFT_Y),
        .RECT_W     (RECT_W),
        .RECT_H     (RECT_H)
    ) u_rect (
        .clk        (clk),
        .reset      (reset),
        .i_pixel_x  (pixelX),
        .i_pixel_y  (pixelY),
        .o_offset_x (offsetX),
        .o_offset_y (offsetY),
        .o_hit      (w_hit)
    );

    assign w_frame_inc = r_frame_cnt + c_frm_w'(1);
    assign w_exit_inc  = r_exit_cnt + c_exit_w'(1);
    assign w_deb_inc   = r_deb_cnt + c_deb_w'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RELEASE;
            r_phase      <= 1'b1;
            r_frame_cnt  <= '0;
            r_exit_cnt   <= '0;
            r_deb_cnt    <= '0;
            r_game_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_exit_cnt   <= w_exit_nxt;
            r_deb_cnt    <= w_deb_nxt;
            r_game_start <= w_game_start_nxt;
        end
    end

    // Every counter and the phase move only on the frame pulse, so the
    // prompt's visibility is constant across a frame.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_frame_nxt      = r_frame_cnt;
        w_exit_nxt       = r_exit_cnt;
        w_deb_nxt        = r_deb_cnt;
        w_game_start_nxt = 1'b0;
        case (r_state)
            RELEASE: begin
                if (startOfFrame && !startKey) begin
                    w_state_nxt = BLINK;
                    w_phase_nxt = 1'b1;
                    w_frame_nxt = '0;
                    w_exit_nxt  = '0;
                    w_deb_nxt   = '0;
                end
            end
            BLINK: begin
                if (startOfFrame) begin
                    // A completed debounce takes priority over a blink expiry.
                    if (startKey && (w_deb_inc == c_deb_n)) begin
                        w_state_nxt = EXIT;
                        w_phase_nxt = 1'b1;
                        w_frame_nxt = '0;
                        w_exit_nxt  = '0;
                        w_deb_nxt   = '0;
                    end else begin
                        w_deb_nxt = startKey ? w_deb_inc : '0;
                        if (w_frame_inc == c_blink_n) begin
                            w_frame_nxt = '0;
                            w_phase_nxt = ~r_phase;
                        end else begin
                            w_frame_nxt = w_frame_inc;
                        end
                    end
                end
            end
            EXIT: begin
                if (startOfFrame) begin
                    if (w_exit_inc == c_exit_n) begin
                        w_state_nxt      = DONE;
                        w_game_start_nxt = 1'b1;
                        w_phase_nxt      = 1'b1;
                        w_frame_nxt      = '0;
                        w_exit_nxt       = '0;
                    end else begin
                        w_exit_nxt = w_exit_inc;
                        if (w_frame_inc == c_xblink_n) begin
                            w_frame_nxt = '0;
                            w_phase_nxt = ~r_phase;
                        end else begin
                            w_frame_nxt = w_frame_inc;
                        end
                    end
                end
            end
            DONE: begin
                if (gameOver) begin
                    w_state_nxt = RELEASE;
                    w_phase_nxt = 1'b1;
                    w_frame_nxt = '0;
                    w_exit_nxt  = '0;
                    w_deb_nxt   = '0;
                end
            end
            default: w_state_nxt = RELEASE;
        endcase
    end

    assign screenActive    = (r_state != DONE);
    assign insideRectangle = w_hit && r_phase && (r_state != DONE);
    assign gameStart       = r_game_start;

endmodule
`default_nettype wire

// File: tb/tb_start_screen_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_start_screen_ctrl                                                     |
// | Scoreboard bench: short synthetic frames against a frame-level model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_start_screen_ctrl;

    localparam int X0 = 320, Y0 = 220, W = 110, H = 50;
    localparam int BLINK_N = 30, DEB_N = 3, EXIT_N = 60, XBLINK_N = 4;
    localparam int FL = 8;   // clocks per synthetic frame

    localparam int M_REL = 0, M_BLINK = 1, M_EXIT = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, startKey, gameOver;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle, screenActive, gameStart;

    start_screen_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .startKey        (startKey),
        .gameOver        (gameOver),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (insideRectangle),
        .screenActive    (screenActive),
        .gameStart       (gameStart)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [10:0] ox;
        logic [10:0] oy;
        logic        ins;
        logic        act;
        logic        gs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_gs_seen = 0;
    int   n_gs_exp  = 0;

    // Frame-level reference: mode plus frames elapsed since entering it.
    int m_mode = M_REL;
    int m_frames = 0;
    int m_run = 0;
    bit m_gs = 1'b0;

    task automatic model_edge(input bit r, input bit sof, input bit key, input bit gov);
        m_gs = 1'b0;
        if (r) begin
            m_mode = M_REL; m_frames = 0; m_run = 0;
        end else begin
            case (m_mode)
                M_REL: if (sof && !key) begin
                    m_mode = M_BLINK; m_frames = 0; m_run = 0;
                end
                M_BLINK: if (sof) begin
                    m_run = key ? m_run + 1 : 0;
                    if (m_run == DEB_N) begin
                        m_mode = M_EXIT; m_frames = 0;
                    end else begin
                        m_frames++;
                    end
                end
                M_EXIT: if (sof) begin
                    m_frames++;
                    if (m_frames == EXIT_N) begin
                        m_mode = M_DONE; m_gs = 1'b1; n_gs_exp++;
                    end
                end
                default: if (gov) m_mode = M_REL;
            endcase
        end
    endtask

    function automatic bit model_visible();
        case (m_mode)
            M_BLINK: return ((m_frames / BLINK_N) % 2) == 0;
            M_EXIT:  return ((m_frames / XBLINK_N) % 2) == 0;
            M_DONE:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Drive one clock of stimulus, then queue what the outputs must show after that edge.
    task automatic cycle(input int x, input int y, input bit sof, input bit key,
                         input bit gov, input bit r);
        exp_t e;
        bit   hit;
        reset = r; pixelX = 11'(x); pixelY = 11'(y);
        startOfFrame = sof; startKey = key; gameOver = gov;
        @(posedge clk);
        #1;
        model_edge(r, sof, key, gov);
        hit   = (x >= X0) && (x < X0 + W) && (y >= Y0) && (y < Y0 + H);
        e.ox  = (!r && hit) ? 11'(x - X0) : 11'd0;
        e.oy  = (!r && hit) ? 11'(y - Y0) : 11'd0;
        e.ins = !r && hit && model_visible();
        e.act = (m_mode != M_DONE);
        e.gs  = m_gs;
        q.push_back(e);
    endtask

    task automatic frame(input bit key, input bit gov, input bit glitch);
        int dx[6] = '{320, 319, 430, 375, 429, 430};
        int dy[6] = '{220, 220, 220, 244, 269, 269};
        for (int c = 0; c < FL; c++) begin
            int x, y;
            bit k;
            if (c >= 1 && c <= 6) begin
                x = dx[c-1]; y = dy[c-1];
            end else if ($urandom_range(3, 0) == 0) begin
                x = $urandom_range(2047, 0); y = $urandom_range(2047, 0);
            end else begin
                x = $urandom_range(450, 300); y = $urandom_range(290, 200);
            end
            k = (c == 0 || !glitch) ? key : 1'($urandom_range(1, 0));
            cycle(x, y, c == 0, k, gov && (c == 2), 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (gameStart) n_gs_seen++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("offsetX", int'(offsetX), int'(e.ox));
            chk("offsetY", int'(offsetY), int'(e.oy));
            chk("insideRectangle", int'(insideRectangle), int'(e.ins));
            chk("screenActive", int'(screenActive), int'(e.act));
            chk("gameStart", int'(gameStart), int'(e.gs));
        end
    end

    initial begin
        // Reset, then hold the key for 10 frames: the screen must not advance.
        cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(320, 220, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);

        // Blink cadence with mid-frame key glitches that must be ignored.
        repeat (100) frame(1'b0, 1'b0, 1'b1);

        // Debounce: 2-high glitch, a low, then 3 consecutive highs.
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        repeat (3) frame(1'b1, 1'b0, 1'b0);

        // Exit sequence with a random key, then some DONE frames.
        repeat (64) frame(1'($urandom_range(1, 0)), 1'b0, 1'b1);

        // gameOver in DONE returns; gameOver in BLINK is ignored.
        frame(1'b1, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        repeat (4) frame(1'b0, 1'b1, 1'b0);
        repeat (3) frame(1'b1, 1'b0, 1'b0);

        // Reset mid-exit.
        repeat (20) frame(1'b0, 1'b0, 1'b0);
        cycle(375, 244, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) frame(1'b0, 1'b0, 1'b0);

        // Free-running random traffic.
        for (int f = 0; f < 150; f++) begin
            frame(1'($urandom_range(3, 0) != 0), 1'($urandom_range(7, 0) == 0), 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("gameStart_pulse_count", n_gs_seen, n_gs_exp);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
